// File: rtl/shift_left_2.sv
// rtl/shift_left_2.sv - fixed logical left shift with combinational and registered outputs
//
// Purpose:
//   Shifts a WIDTH-bit word left by SHAMT bits with zero fill from the LSB end.
//   The top SHAMT bits are discarded. The design has no sign preservation and no rotate.
//   It converts word offsets and jump-target fields into byte offsets.
//   A one-cycle registered copy is provided for pipelined consumers.
//
// Parameters:
//   WIDTH  data width of input and outputs (default 32)
//   SHAMT  fixed shift amount, legal range 1..WIDTH-1 (default 2)
//
// Optional feature macro: SHIFTLEFT2_OVF_EN
//   When defined, this adds the lost-bit flag Ovf and its registered copy OvfQ.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (clears registered outputs only)
//   ShiftIn    in   WIDTH  operand word
//   ShiftOut   out  WIDTH  combinational ShiftIn << SHAMT
//   Ovf        out  1      (SHIFTLEFT2_OVF_EN) high when any shifted-out bit is 1
//   OvfQ       out  1      (SHIFTLEFT2_OVF_EN) Ovf delayed one cycle
//   ShiftOutQ  out  WIDTH  ShiftOut delayed one cycle

module shift_left_2 #(
  parameter int WIDTH = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ShiftIn,
  output logic [WIDTH-1:0] ShiftOut,
`ifdef SHIFTLEFT2_OVF_EN
  output logic             Ovf,
  output logic             OvfQ,
`endif
  output logic [WIDTH-1:0] ShiftOutQ
);

  generate
    if (SHAMT < 1 || SHAMT > WIDTH - 1) begin : g_bad_shamt
      $error("shift_left_2: SHAMT must be in 1..WIDTH-1");
    end
  endgenerate

  // Low SHAMT bits are constant zero, so X/Z on ShiftIn never reaches them.
  assign ShiftOut = {ShiftIn[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      ShiftOutQ <= '0;
    end else begin
      ShiftOutQ <= ShiftOut;
    end
  end

`ifdef SHIFTLEFT2_OVF_EN
  // Any set bit in the discarded field means the shifted value lost information.
  assign Ovf = |ShiftIn[WIDTH-1:WIDTH-SHAMT];

  always_ff @(posedge clk) begin
    if (rst) begin
      OvfQ <= 1'b0;
    end else begin
      OvfQ <= Ovf;
    end
  end
`else
  // The discarded top bits feed nothing when the overflow flag is not built.
  logic unused_top_bits;
  assign unused_top_bits = ^ShiftIn[WIDTH-1:WIDTH-SHAMT];
`endif

endmodule

// File: tb/tb_shift_left_2.sv
// tb/tb_shift_left_2.sv - directed and random checks for shift_left_2

module tb_shift_left_2;

  logic        clk;
  logic        rst;
  logic [31:0] ShiftIn;
  logic [31:0] ShiftOut;
  logic [31:0] ShiftOutQ;
`ifdef SHIFTLEFT2_OVF_EN
  logic        Ovf;
  logic        OvfQ;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  shift_left_2 #(.WIDTH(32), .SHAMT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ShiftIn   (ShiftIn),
    .ShiftOut  (ShiftOut),
`ifdef SHIFTLEFT2_OVF_EN
    .Ovf       (Ovf),
    .OvfQ      (OvfQ),
`endif
    .ShiftOutQ (ShiftOutQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Directed vectors with hand-computed results.
  logic [31:0] vin [8] = '{32'h0000_0001, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000,
                           32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1234_5678};
  logic [31:0] vout [8] = '{32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
                            32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h48D1_59E0};
  logic        vovf [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [31:0] prev_exp;
    logic [31:0] rnd;

    rst = 1'b1;
    ShiftIn = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", ShiftOutQ, 32'h0);
    check("reset_comb", ShiftOut, 32'h0);
`ifdef SHIFTLEFT2_OVF_EN
    check("reset_ovfq", {31'b0, OvfQ}, 32'h0);
`endif

    // The combinational path ignores reset, and the register stays cleared.
    ShiftIn = 32'h0000_0001;
    #1;
    check("rst_comb", ShiftOut, 32'h0000_0004);
    @(posedge clk);
    #1;
    check("rst_hold_q", ShiftOutQ, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ShiftIn = vin[i];
      #1;
      check($sformatf("vec%0d_comb", i), ShiftOut, vout[i]);
`ifdef SHIFTLEFT2_OVF_EN
      check($sformatf("vec%0d_ovf", i), {31'b0, Ovf}, {31'b0, vovf[i]});
`endif
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), ShiftOutQ, vout[i]);
`ifdef SHIFTLEFT2_OVF_EN
      check($sformatf("vec%0d_ovfq", i), {31'b0, OvfQ}, {31'b0, vovf[i]});
`endif
    end

    // Reset for a single edge in mid-stream.
    ShiftIn = 32'h0000_0003;
    @(posedge clk);
    #1;
    check("mid_pre_q", ShiftOutQ, 32'h0000_000C);
    rst = 1'b1;
    ShiftIn = 32'h0000_0005;
    @(posedge clk);
    #1;
    check("mid_rst_q", ShiftOutQ, 32'h0);
    check("mid_rst_comb", ShiftOut, 32'h0000_0014);
    rst = 1'b0;
    ShiftIn = 32'h0000_0006;
    @(posedge clk);
    #1;
    check("mid_resume_q", ShiftOutQ, 32'h0000_0018);

    // Random sweep of 1000 vectors.
    prev_exp = 32'h0000_0018;
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom;
      ShiftIn = rnd;
      #1;
      check("rand_comb", ShiftOut, {rnd[29:0], 2'b00});
`ifdef SHIFTLEFT2_OVF_EN
      check("rand_ovf", {31'b0, Ovf}, {31'b0, (rnd[31] | rnd[30])});
`endif
      @(posedge clk);
      #1;
      check("rand_q", ShiftOutQ, {rnd[29:0], 2'b00});
      prev_exp = {rnd[29:0], 2'b00};
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
